// File: rtl/cal_rd_pkg.sv
// Shared types and constants for the calibration EEPROM reader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cal_rd_pkg;

    localparam int ADR_W = 15;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_EMIT,
        ST_FIN,
        ST_ERR
    } state_t;

endpackage

// File: rtl/cal_eeprom_reader_if.sv
// EEPROM byte-read bus plus the address/data stream toward the calibration loader.
// Latency: n/a (wires only).
// Backpressure: none; the EEPROM side paces requests with ee_ack, the stream side is strobe-only.
interface cal_eeprom_reader_if;
    import cal_rd_pkg::*;

    logic             ee_req;
    logic [ADR_W-1:0] ee_adr;
    logic             ee_ack;
    logic [7:0]       ee_data;
    logic             ee_err;

    logic [ADR_W-1:0] ADR;
    logic [7:0]       DATA;
    logic [7:0]       DATA_DFF;
    logic             EN;

    modport master (
        output ee_req, ee_adr, ADR, DATA, DATA_DFF, EN,
        input  ee_ack, ee_data, ee_err
    );

    modport slave (
        input  ee_req, ee_adr, ADR, DATA, DATA_DFF, EN,
        output ee_ack, ee_data, ee_err
    );

endinterface

// File: rtl/cal_crc16.sv
// CRC-16-CCITT (MSB-first) accumulator, one byte per enabled cycle.
// Latency: register updates on the edge where en=1; crc reflects it the next cycle.
// Backpressure: none; clr has priority over en.
module cal_crc16
    import cal_rd_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  din,
    output logic [15:0] crc
);

    logic [15:0] crc_q;
    logic [15:0] crc_nxt;

    // Fold the byte into the top of the remainder, then shift out eight bits.
    always_comb begin
        crc_nxt = crc_q ^ {din, 8'h00};
        for (int i = 0; i < 8; i++) begin
            crc_nxt = crc_nxt[15] ? ((crc_nxt << 1) ^ CRC_POLY) : (crc_nxt << 1);
        end
    end

    // Remainder register with clear-to-init and enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   crc_q <= CRC_INIT;
        else if (clr) crc_q <= CRC_INIT;
        else if (en)  crc_q <= crc_nxt;
    end

    assign crc = crc_q;

endmodule

// File: rtl/cal_eeprom_reader.sv
// Walks EEPROM 0..LAST_ADR via req/ack byte reads and re-emits each byte as an EN-strobed stream.
// Latency: start->ee_req 1 cycle, ee_ack->EN 1 cycle, min 3 cycles per byte; done 1 cycle after last EN.
// Backpressure: none downstream; upstream waits up to TIMEOUT cycles for ee_ack. CAL_RD_CRC_EN adds CRC check.
module cal_eeprom_reader
    import cal_rd_pkg::*;
#(
    parameter logic [ADR_W-1:0] LAST_ADR = 15'h7FFF,
    parameter int               TIMEOUT  = 1023
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    cal_eeprom_reader_if.master  bus,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout_err,
    output logic                 crc_err
);

    localparam logic [9:0] TO_LAST = 10'(TIMEOUT - 1);

    state_t           state, state_nxt;
    logic [ADR_W-1:0] adr_cnt;
    logic [9:0]       tcnt;
    logic [ADR_W-1:0] adr_q;
    logic [7:0]       data_q;
    logic [7:0]       dff_q;
    logic [7:0]       shadow;
    logic             terr_q;
    logic             accept;

    assign accept = (state == ST_IDLE) && start;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state selection; ack outranks both error and timeout in WAIT.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_REQ;
            ST_REQ:  state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (bus.ee_ack)           state_nxt = ST_EMIT;
                else if (bus.ee_err)      state_nxt = ST_ERR;
                else if (tcnt == TO_LAST) state_nxt = ST_ERR;
            end
            ST_EMIT: state_nxt = (adr_cnt == LAST_ADR) ? ST_FIN : ST_REQ;
            ST_FIN:  state_nxt = ST_IDLE;
            ST_ERR:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Address counter, wait counter, byte latch and previous-byte shadow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adr_cnt <= '0;
            tcnt    <= '0;
            adr_q   <= '0;
            data_q  <= '0;
            dff_q   <= '0;
            shadow  <= '0;
        end else begin
            case (state)
                ST_IDLE: if (start) begin
                    adr_cnt <= '0;
                    shadow  <= '0;
                end
                ST_REQ:  tcnt <= '0;
                ST_WAIT: begin
                    tcnt <= tcnt + 10'd1;
                    if (bus.ee_ack) begin
                        adr_q  <= adr_cnt;
                        data_q <= bus.ee_data;
                        dff_q  <= shadow;
                    end
                end
                ST_EMIT: begin
                    shadow <= data_q;
                    // Saturate at LAST_ADR so a full 32K walk never wraps to 0.
                    if (adr_cnt != LAST_ADR) adr_cnt <= adr_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Sticky abort flag: set on entry to ERR, cleared by an accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                         terr_q <= 1'b0;
        else if (accept)                                    terr_q <= 1'b0;
        else if (state == ST_WAIT && state_nxt == ST_ERR)   terr_q <= 1'b1;
    end

`ifdef CAL_RD_CRC_EN
    localparam logic [ADR_W-1:0] CRC_LAST = LAST_ADR - 15'd2;

    logic [15:0] crc_val;
    logic        crc_en;
    logic        crc_q;

    // Only payload bytes feed the CRC; the last two bytes are the stored value.
    assign crc_en = (state == ST_EMIT) && (adr_cnt <= CRC_LAST);

    cal_crc16 u_crc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .en    (crc_en),
        .din   (data_q),
        .crc   (crc_val)
    );

    // On the final EMIT, data_q is the stored high byte and shadow the low byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      crc_q <= 1'b0;
        else if (accept) crc_q <= 1'b0;
        else if (state == ST_EMIT && state_nxt == ST_FIN && crc_val != {data_q, shadow})
            crc_q <= 1'b1;
    end

    assign crc_err = crc_q;
`else
    assign crc_err = 1'b0;
`endif

    assign bus.ee_req   = (state == ST_REQ);
    assign bus.ee_adr   = adr_cnt;
    assign bus.EN       = (state == ST_EMIT);
    assign bus.ADR      = adr_q;
    assign bus.DATA     = data_q;
    assign bus.DATA_DFF = dff_q;
    assign busy         = (state == ST_REQ) || (state == ST_WAIT) || (state == ST_EMIT);
    assign done         = (state == ST_FIN);
    assign timeout_err  = terr_q;

endmodule

// File: tb/tb_cal_eeprom_reader.sv
// Directed-plus-random bench for cal_eeprom_reader with an EEPROM responder and stream monitor.
// Latency: n/a.
// Backpressure: n/a.
module tb_cal_eeprom_reader;
    import cal_rd_pkg::*;

    localparam logic [14:0] LAST = 15'd7;
    localparam int          TO   = 15;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic busy, done, timeout_err, crc_err;

    cal_eeprom_reader_if bus ();

    cal_eeprom_reader #(.LAST_ADR(LAST), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .bus         (bus),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err),
        .crc_err     (crc_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // EEPROM contents and responder behaviour knobs.
    logic [7:0] mem [0:7];
    int no_ack_adr  = -1;
    int err_adr     = -1;
    int err_ack_adr = -1;
    int dly_min     = 2;
    int dly_max     = 2;
    bit stray_ack   = 1'b0;

    // Monitor observations.
    logic [14:0] q_adr [$];
    logic [7:0]  q_dat [$];
    logic [7:0]  q_dff [$];
    int   cyc = 0;
    int   done_cnt = 0, done_cyc = -1, last_en_cyc = -1, min_gap = 1000;
    int   last_req_cyc = -1, idle_cyc = -1;
    logic crc_at_done = 1'b0;
    logic prev_busy = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bit-serial LFSR form of CRC-16-CCITT over mem[0..n-1].
    function automatic logic [15:0] crc16(input int n);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            for (int b = 7; b >= 0; b--) begin
                fb = c[15] ^ mem[i][b];
                c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
            end
        end
        return c;
    endfunction

    // EEPROM responder: answers each request after a random delay, or errs / stays silent.
    initial begin
        int a;
        int d;
        bus.ee_ack  = 1'b0;
        bus.ee_data = 8'h00;
        bus.ee_err  = 1'b0;
        forever begin
            if (!(rst_n && bus.ee_req)) begin
                @(posedge clk); #1;
                continue;
            end
            a = int'(bus.ee_adr);
            if (a == no_ack_adr) begin
                @(posedge clk); #1;
                continue;
            end
            d = $urandom_range(dly_max, dly_min);
            repeat (d) @(posedge clk);
            #1;
            if (a == err_adr) begin
                bus.ee_err = 1'b1;
            end else begin
                bus.ee_ack  = 1'b1;
                bus.ee_data = mem[a];
                if (a == err_ack_adr) bus.ee_err = 1'b1;
            end
            @(posedge clk); #1;
            bus.ee_err = 1'b0;
            if (stray_ack && bus.ee_ack) begin
                // Ack held into EMIT with garbage data; must be ignored.
                bus.ee_data = ~bus.ee_data;
                @(posedge clk); #1;
            end
            bus.ee_ack = 1'b0;
        end
    end

    // Stream monitor: records strobes, done pulses and busy edges.
    initial begin
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (bus.EN) begin
                q_adr.push_back(bus.ADR);
                q_dat.push_back(bus.DATA);
                q_dff.push_back(bus.DATA_DFF);
                if (last_en_cyc >= 0 && (cyc - last_en_cyc) < min_gap) min_gap = cyc - last_en_cyc;
                last_en_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc    = cyc;
                crc_at_done = crc_err;
            end
            if (bus.ee_req) last_req_cyc = cyc;
            if (prev_busy && !busy) idle_cyc = cyc;
            prev_busy = busy;
        end
    end

    task automatic check_reset(input string tag);
        check({tag, "_ee_req"},   {31'd0, bus.ee_req},   32'd0);
        check({tag, "_ee_adr"},   {17'd0, bus.ee_adr},   32'd0);
        check({tag, "_en"},       {31'd0, bus.EN},       32'd0);
        check({tag, "_adr"},      {17'd0, bus.ADR},      32'd0);
        check({tag, "_data"},     {24'd0, bus.DATA},     32'd0);
        check({tag, "_data_dff"}, {24'd0, bus.DATA_DFF}, 32'd0);
        check({tag, "_busy"},     {31'd0, busy},         32'd0);
        check({tag, "_done"},     {31'd0, done},         32'd0);
        check({tag, "_terr"},     {31'd0, timeout_err},  32'd0);
        check({tag, "_crc_err"},  {31'd0, crc_err},      32'd0);
    endtask

    // One load: pulse start, wait for the sequencer to go idle, compare against the memory image.
    task automatic run_load(input string tag, input bit extra_start, input int exp_en,
                            input bit exp_done, input bit exp_terr, input bit exp_crc);
        int n;
        int lim;
        logic [7:0] exp_dff;
        q_adr.delete(); q_dat.delete(); q_dff.delete();
        done_cnt = 0; last_en_cyc = -1; min_gap = 1000; idle_cyc = -1;
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        n = 0;
        while (busy && n < 4000) begin
            @(posedge clk); #1;
            n++;
            start = (extra_start && (n == 5 || n == 13)) ? 1'b1 : 1'b0;
        end
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
        check({tag, "_en_count"}, q_adr.size(), exp_en);
        lim = (q_adr.size() < exp_en) ? q_adr.size() : exp_en;
        for (int i = 0; i < lim; i++) begin
            exp_dff = (i == 0) ? 8'h00 : mem[i-1];
            check($sformatf("%s_adr%0d", tag, i), {17'd0, q_adr[i]}, i);
            check($sformatf("%s_dat%0d", tag, i), {24'd0, q_dat[i]}, {24'd0, mem[i]});
            check($sformatf("%s_dff%0d", tag, i), {24'd0, q_dff[i]}, {24'd0, exp_dff});
        end
        check({tag, "_done_count"}, done_cnt, {31'd0, exp_done});
        check({tag, "_terr"}, {31'd0, timeout_err}, {31'd0, exp_terr});
        if (exp_done) begin
            check({tag, "_done_after_last_en"}, done_cyc, last_en_cyc + 1);
            check({tag, "_crc_at_done"}, {31'd0, crc_at_done}, {31'd0, exp_crc});
        end
        if (exp_en > 1) check({tag, "_en_gap_ge3"}, {31'd0, (min_gap >= 3)}, 32'd1);
    endtask

    initial begin
        int n;
        logic [15:0] crc;

        repeat (3) @(posedge clk);
        #1;
        check_reset("rst");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic walk: byte = addr + 0x10, ack two cycles after request.
        for (int i = 0; i < 8; i++) mem[i] = 8'(i + 8'h10);
        run_load("basic", 1'b0, 8, 1'b1, 1'b0, 1'b0);

        // Start pulses while busy are ignored.
        run_load("start_busy", 1'b1, 8, 1'b1, 1'b0, 1'b0);

        // Silent EEPROM at address 3: abort after TIMEOUT wait cycles.
        no_ack_adr = 3;
        run_load("timeout", 1'b0, 3, 1'b0, 1'b1, 1'b0);
        check("timeout_req_to_idle", idle_cyc - last_req_cyc, TO + 1);
        no_ack_adr = -1;

        // Error coinciding with ack is overridden by the ack; also clears the sticky flag.
        err_ack_adr = 2;
        run_load("err_with_ack", 1'b0, 8, 1'b1, 1'b0, 1'b0);
        err_ack_adr = -1;

        // Error alone at address 5 aborts after five bytes.
        err_adr = 5;
        run_load("err_alone", 1'b0, 5, 1'b0, 1'b1, 1'b0);
        err_adr = -1;

        // Reset asserted while waiting on address 4.
        no_ack_adr = 4;
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        n = 0;
        while (!(bus.ee_req && bus.ee_adr == 15'd4) && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        check("mid_reset_reached_adr4", {17'd0, bus.ee_adr}, 32'd4);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #2;
        check_reset("mid_rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        no_ack_adr = -1;
        for (int i = 0; i < 8; i++) mem[i] = 8'($urandom);
        run_load("after_rst", 1'b0, 8, 1'b1, 1'b0, 1'b0);

        // Random contents, random ack latency, occasional ack held into EMIT.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 8; i++) mem[i] = 8'($urandom);
            dly_min   = 1;
            dly_max   = 6;
            stray_ack = 1'($urandom_range(1, 0));
            run_load($sformatf("rand%0d", r), 1'b0, 8, 1'b1, 1'b0, 1'b0);
        end
        stray_ack = 1'b0;

`ifdef CAL_RD_CRC_EN
        // Payload bytes 0..5, stored CRC low at 6, high at 7.
        for (int i = 0; i < 6; i++) mem[i] = 8'($urandom);
        crc    = crc16(6);
        mem[6] = crc[7:0];
        mem[7] = crc[15:8];
        run_load("crc_good", 1'b0, 8, 1'b1, 1'b0, 1'b0);
        mem[2] = mem[2] ^ 8'h5A;
        run_load("crc_bad", 1'b0, 8, 1'b1, 1'b0, 1'b1);
        check("crc_bad_sticky", {31'd0, crc_err}, 32'd1);
        mem[2] = mem[2] ^ 8'h5A;
        run_load("crc_clear", 1'b0, 8, 1'b1, 1'b0, 1'b0);
`else
        crc = 16'h0000;
        check("crc_tied_low", {31'd0, crc_err}, {16'd0, crc});
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cal_eeprom_reader.md
# cal_eeprom_reader

Sequencer that walks the calibration EEPROM from address 0 to a programmed last address, fetching one byte per request over a req/ack byte-read interface and re-emitting each byte as a one-cycle-strobed address/data stream. Each strobe carries the byte at that address and the byte from the previous address. It is the producer side of the calibration-load path: its `ADR`/`DATA`/`DATA_DFF`/`EN` outputs drive the calibration register/RAM loader directly. It also reports completion, timeout and (optionally) CRC status to the control logic.

## Interface
- `LAST_ADR`, 15'h7FFF: final EEPROM byte address read; the stream covers 0..LAST_ADR inclusive.
- `TIMEOUT`, 1023: max cycles from `ee_req` to `ee_ack` before aborting; counter is 10 bits wide.
- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  one-cycle pulse that begins a load; ignored while `busy`=1.
- `ee_req`  out  1  byte-read request to the EEPROM controller.
- `ee_adr`  out  15  byte address of the request.
- `ee_ack`  in  1  one-cycle pulse: `ee_data` valid.
- `ee_data`  in  8  read byte.
- `ee_err`  in  1  controller error (NAK/bus fault); sampled only in WAIT.
- `ADR`  out  15  address of the emitted byte.
- `DATA`  out  8  byte at `ADR`.
- `DATA_DFF`  out  8  byte at `ADR`-1; 8'h00 when `ADR`=0.
- `EN`  out  1  one-cycle strobe qualifying `ADR`/`DATA`/`DATA_DFF`.
- `busy`  out  1  load in progress.
- `done`  out  1  one-cycle pulse on successful completion.
- `timeout_err`  out  1  sticky: aborted on timeout or `ee_err`; cleared by next accepted `start`.
- `crc_err`  out  1  sticky CRC mismatch; cleared by next accepted `start`.

## Operation
- States: IDLE, REQ, WAIT, EMIT, FIN, ERR.
- IDLE: when `start`=1, clear address counter, `DATA_DFF` shadow, `timeout_err` and `crc_err`; go to REQ.
- REQ: drive `ee_req`=1 with `ee_adr`=counter for exactly one cycle; clear the timeout counter; go to WAIT.
- WAIT: hold `ee_adr`.
  - `ee_ack`=1: latch `ee_data`; go to EMIT.
  - else `ee_err`=1: go to ERR.
  - else timeout counter reaches `TIMEOUT`: go to ERR.
  - `ee_ack` wins when it coincides with `ee_err` or the timeout.
- EMIT:
  - `EN`=1; `ADR`=counter; `DATA`=latched byte; `DATA_DFF`=shadow.
  - Shadow updates to the latched byte.
  - If counter==`LAST_ADR` go to FIN; otherwise counter+1 and go to REQ.
- FIN: pulse `done`, drop `busy`, return to IDLE.
- ERR: set `timeout_err`, drop `busy`, return to IDLE. No further `EN`. Already-emitted bytes stand.
- `busy`=1 in REQ, WAIT and EMIT.
- `ee_ack` outside WAIT is ignored.
- Counter never wraps: it stops at `LAST_ADR`. With `LAST_ADR`=15'h7FFF there is no rollover to 0.
- `ADR`/`DATA`/`DATA_DFF` hold their last values between strobes.

## Timing
- Reset values:
  - State IDLE.
  - `ee_req`, `EN`, `busy`, `done`, `timeout_err`, `crc_err` = 0.
  - `ee_adr`, `ADR` = 0.
  - `DATA`, `DATA_DFF`, shadow = 0.
- Reset mid-load aborts immediately; no `done`.
- `start` → `ee_req`: 1 cycle (IDLE→REQ on the next edge).
- `ee_ack` sampled high → `EN` high on the following cycle.
- Minimum byte period: 3 cycles (REQ, WAIT with immediate ack, EMIT). Back-to-back `EN` pulses are therefore at least 3 cycles apart.
- Timeout: ERR is entered on the edge after `TIMEOUT` cycles spent in WAIT without ack.
- `done` is asserted the cycle after the last `EN`.

## Configuration
- `CAL_RD_CRC_EN` defined:
  - CRC-16-CCITT (poly 16'h1021, init 16'hFFFF, MSB-first) is accumulated over bytes 0..`LAST_ADR`-2.
  - Bytes `LAST_ADR`-1 (low) and `LAST_ADR` (high) hold the expected CRC.
  - On the FIN transition, `crc_err` is set if they differ.
  - All bytes, including the stored CRC bytes, are still emitted on `EN`.
- `CAL_RD_CRC_EN` undefined: no CRC logic; `crc_err` is tied 0.

## Structure
- Package `cal_rd_pkg` holds:
  - state enum;
  - CRC polynomial/init constants;
  - 15-bit address width constant.
- Sub-module `cal_crc16`: byte-wide combinational CRC update plus register with clear and enable. Instantiated only under `CAL_RD_CRC_EN`.

## Test plan
- `LAST_ADR`=15'h0007, EEPROM model returns byte = addr+8'h10, ack 2 cycles after req → 8 `EN` pulses with `ADR` 0..7, `DATA` 10..17, `DATA_DFF` 00,10..16; `done` once; `timeout_err`=0.
- `start` pulsed while `busy` → ignored; address sequence unchanged, exactly one `done`.
- No ack at address 3, `TIMEOUT`=15 → ERR 15 cycles into WAIT; `timeout_err`=1, `busy`=0, no `done`, exactly 3 `EN` pulses.
- `ee_err` and `ee_ack` in the same cycle at address 2 → byte emitted, load continues normally; `ee_err` alone at address 5 → `timeout_err`=1.
- `rst_n` low for 1 cycle mid-WAIT → all outputs return to reset values; a new `start` reloads from address 0.
- `CAL_RD_CRC_EN` defined, `LAST_ADR`=15'h0005, bytes 00..03 = 31,32,33,34 and bytes 04,05 = correct CRC → `crc_err`=0. Corrupt byte 02 → `crc_err`=1 together with `done`.
